// File: rtl/branch_pkg.sv
// Shared definitions for the branch sequencer: branch opcodes, FSM state encoding
// and the legal-opcode decode used on the ID-stage br_op field.
package branch_pkg;

  localparam logic [3:0] OP_BEQ = 4'b0100;
  localparam logic [3:0] OP_BNE = 4'b0101;
  localparam logic [3:0] OP_BGT = 4'b0110;
  localparam logic [3:0] OP_BLT = 4'b0111;
  localparam logic [3:0] OP_BGE = 4'b1000;
  localparam logic [3:0] OP_BLE = 4'b1001;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WAIT  = 2'd1,
    EVAL  = 2'd2,
    FLUSH = 2'd3
  } br_state_e;

  function automatic logic is_branch_op(input logic [3:0] op);
    return (op >= OP_BEQ) && (op <= OP_BLE);
  endfunction

endpackage

// File: rtl/branch_cmp.sv
// Combinational branch condition evaluator: equality compares are bitwise,
// ordering compares treat both operands as two's-complement.
module branch_cmp
  import branch_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic [3:0]        op,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              taken
);

  always_comb begin
    taken = 1'b0;
    case (op)
      OP_BEQ:  taken = (a == b);
      OP_BNE:  taken = (a != b);
      OP_BGT:  taken = ($signed(a) >  $signed(b));
      OP_BLT:  taken = ($signed(a) <  $signed(b));
      OP_BGE:  taken = ($signed(a) >= $signed(b));
      OP_BLE:  taken = ($signed(a) <= $signed(b));
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_seq_ctrl.sv
// Branch resolution sequencer between ID/hazard logic and the PC-select mux.
// Optional performance counters are built only when BRANCH_PERF_EN is defined.
module branch_seq_ctrl
  import branch_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 32,
  parameter int CNT_W  = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              br_valid,
  input  logic [3:0]        br_op,
  input  logic [DATA_W-1:0] rs_data,
  input  logic [DATA_W-1:0] rt_data,
  input  logic              src_busy,
  input  logic [15:0]       br_offset,
  input  logic [ADDR_W-1:0] next_pc,
  output logic              id_stall,
  output logic              pc_redirect,
  output logic [ADDR_W-1:0] pc_target,
  output logic              if_flush,
  output logic              br_err,
  output logic [CNT_W-1:0]  perf_branches,
  output logic [CNT_W-1:0]  perf_taken,
  output logic [CNT_W-1:0]  perf_stall
);

  br_state_e state_q, state_d;

  logic [3:0]        op_q, op_d;
  logic [DATA_W-1:0] rs_q, rs_d;
  logic [DATA_W-1:0] rt_q, rt_d;
  logic [ADDR_W-1:0] tgt_q, tgt_d;
  logic [ADDR_W-1:0] pc_target_q, pc_target_d;

  logic              op_legal;
  logic              latch_en;
  logic              taken;
  logic [ADDR_W-1:0] off_ext;
  logic [ADDR_W-1:0] br_target;

  assign op_legal  = is_branch_op(br_op);
  assign off_ext   = {{(ADDR_W-16){br_offset[15]}}, br_offset};
  assign br_target = next_pc + (off_ext << 2);

  branch_cmp #(.DATA_W(DATA_W)) u_cmp (
    .op    (op_q),
    .a     (rs_q),
    .b     (rt_q),
    .taken (taken)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q     <= IDLE;
      op_q        <= '0;
      rs_q        <= '0;
      rt_q        <= '0;
      tgt_q       <= '0;
      pc_target_q <= '0;
    end else begin
      state_q     <= state_d;
      op_q        <= op_d;
      rs_q        <= rs_d;
      rt_q        <= rt_d;
      tgt_q       <= tgt_d;
      pc_target_q <= pc_target_d;
    end
  end

  // Operands are captured only once the hazard unit reports them ready.
  always_comb begin
    state_d  = state_q;
    latch_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (br_valid && op_legal) begin
          if (src_busy) begin
            state_d = WAIT;
          end else begin
            latch_en = 1'b1;
            state_d  = EVAL;
          end
        end
      end
      WAIT: begin
        if (!src_busy) begin
          latch_en = 1'b1;
          state_d  = EVAL;
        end
      end
      EVAL:    state_d = taken ? FLUSH : IDLE;
      FLUSH:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    op_d        = latch_en ? br_op     : op_q;
    rs_d        = latch_en ? rs_data   : rs_q;
    rt_d        = latch_en ? rt_data   : rt_q;
    tgt_d       = latch_en ? br_target : tgt_q;
    pc_target_d = pc_redirect ? tgt_q  : pc_target_q;
  end

  // IDLE outputs depend on live ID inputs, so they are masked while reset is held.
  always_comb begin
    id_stall    = 1'b0;
    pc_redirect = 1'b0;
    if_flush    = 1'b0;
    br_err      = 1'b0;
    case (state_q)
      IDLE: begin
        id_stall = br_valid && op_legal && !reset;
        br_err   = br_valid && !op_legal && !reset;
      end
      WAIT: id_stall = 1'b1;
      EVAL: begin
        pc_redirect = taken;
        if_flush    = taken;
      end
      default: ;
    endcase
  end

  assign pc_target = pc_redirect ? tgt_q : pc_target_q;

`ifdef BRANCH_PERF_EN
  logic [CNT_W-1:0] perf_branches_q, perf_branches_d;
  logic [CNT_W-1:0] perf_taken_q, perf_taken_d;
  logic [CNT_W-1:0] perf_stall_q, perf_stall_d;

  always_comb begin
    perf_branches_d = perf_branches_q;
    perf_taken_d    = perf_taken_q;
    perf_stall_d    = perf_stall_q;
    if (state_q == EVAL) perf_branches_d = perf_branches_q + CNT_W'(1);
    if (pc_redirect)     perf_taken_d    = perf_taken_q + CNT_W'(1);
    if (state_q == WAIT) perf_stall_d    = perf_stall_q + CNT_W'(1);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_branches_q <= '0;
      perf_taken_q    <= '0;
      perf_stall_q    <= '0;
    end else begin
      perf_branches_q <= perf_branches_d;
      perf_taken_q    <= perf_taken_d;
      perf_stall_q    <= perf_stall_d;
    end
  end

  assign perf_branches = perf_branches_q;
  assign perf_taken    = perf_taken_q;
  assign perf_stall    = perf_stall_q;
`else
  assign perf_branches = '0;
  assign perf_taken    = '0;
  assign perf_stall    = '0;
`endif

endmodule

// File: tb/tb_branch_seq_ctrl.sv
// Self-checking bench for branch_seq_ctrl: a transaction-level model sets the
// expected outputs for each cycle and a negedge process compares every cycle.
module tb_branch_seq_ctrl;

  localparam logic [3:0] T_BEQ = 4'b0100;
  localparam logic [3:0] T_BNE = 4'b0101;
  localparam logic [3:0] T_BGT = 4'b0110;
  localparam logic [3:0] T_BLT = 4'b0111;
  localparam logic [3:0] T_BGE = 4'b1000;
  localparam logic [3:0] T_BLE = 4'b1001;

`ifdef BRANCH_PERF_EN
  localparam bit PERF_ON = 1'b1;
`else
  localparam bit PERF_ON = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic        br_valid;
  logic [3:0]  br_op;
  logic [31:0] rs_data, rt_data;
  logic        src_busy;
  logic [15:0] br_offset;
  logic [31:0] next_pc;
  logic        id_stall, pc_redirect, if_flush, br_err;
  logic [31:0] pc_target, perf_branches, perf_taken, perf_stall;

  int n_checks = 0;
  int n_fail   = 0;
  bit check_en = 1'b0;

  logic        exp_stall, exp_redirect, exp_flush, exp_err;
  logic [31:0] exp_pc_target, exp_branches, exp_taken, exp_stallcnt, m_hold;
  bit          pend_br, pend_tk, pend_st;

  branch_seq_ctrl #(.DATA_W(32), .ADDR_W(32), .CNT_W(32)) dut (
    .clk           (clk),
    .reset         (reset),
    .br_valid      (br_valid),
    .br_op         (br_op),
    .rs_data       (rs_data),
    .rt_data       (rt_data),
    .src_busy      (src_busy),
    .br_offset     (br_offset),
    .next_pc       (next_pc),
    .id_stall      (id_stall),
    .pc_redirect   (pc_redirect),
    .pc_target     (pc_target),
    .if_flush      (if_flush),
    .br_err        (br_err),
    .perf_branches (perf_branches),
    .perf_taken    (perf_taken),
    .perf_stall    (perf_stall)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s at %0t: got 0x%08h, want 0x%08h", name, $time, act, req);
    end
  endtask

  task automatic check_all();
    checkOutput("id_stall",      32'(id_stall),    32'(exp_stall));
    checkOutput("pc_redirect",   32'(pc_redirect), 32'(exp_redirect));
    checkOutput("if_flush",      32'(if_flush),    32'(exp_flush));
    checkOutput("br_err",        32'(br_err),      32'(exp_err));
    checkOutput("pc_target",     pc_target,        exp_pc_target);
    checkOutput("perf_branches", perf_branches,    exp_branches);
    checkOutput("perf_taken",    perf_taken,       exp_taken);
    checkOutput("perf_stall",    perf_stall,       exp_stallcnt);
  endtask

  always @(negedge clk) begin
    if (check_en) check_all();
  end

  function automatic logic model_taken(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b);
    int signed sa, sb;
    sa = int'($signed(a));
    sb = int'($signed(b));
    case (op)
      T_BEQ:   return a == b;
      T_BNE:   return a != b;
      T_BGT:   return sa > sb;
      T_BLT:   return sa < sb;
      T_BGE:   return sa >= sb;
      T_BLE:   return sa <= sb;
      default: return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] model_target(input logic [31:0] npc, input logic [15:0] off);
    int signed o;
    o = int'($signed(off));
    return npc + 32'(o * 4);
  endfunction

  task automatic clear_exp();
    exp_stall     = 1'b0;
    exp_redirect  = 1'b0;
    exp_flush     = 1'b0;
    exp_err       = 1'b0;
    exp_pc_target = m_hold;
  endtask

  // Advance one cycle; counter events flagged last cycle become visible now.
  task automatic step();
    @(posedge clk);
    #1;
    if (PERF_ON && pend_br) exp_branches = exp_branches + 32'd1;
    if (PERF_ON && pend_tk) exp_taken    = exp_taken + 32'd1;
    if (PERF_ON && pend_st) exp_stallcnt = exp_stallcnt + 32'd1;
    pend_br = 1'b0;
    pend_tk = 1'b0;
    pend_st = 1'b0;
  endtask

  task automatic idle_cycle();
    step();
    br_valid = 1'b0;
    src_busy = 1'b0;
    clear_exp();
  endtask

  // One legal branch: operands are garbage until the release cycle.
  task automatic applyStimulus(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                               input logic [15:0] off, input logic [31:0] npc, input int n_busy,
                               input bit lit_tgt_en, input logic [31:0] lit_tgt,
                               input bit lit_stall_en, input logic [31:0] lit_stall);
    logic        tk;
    logic [31:0] tgt;
    tk  = model_taken(op, rs, rt);
    tgt = model_target(npc, off);
    for (int c = 0; c <= n_busy; c++) begin
      step();
      br_valid  = 1'b1;
      br_op     = op;
      br_offset = off;
      next_pc   = npc;
      src_busy  = (c < n_busy);
      rs_data   = (c == n_busy) ? rs : ~rs;
      rt_data   = rt;
      clear_exp();
      exp_stall = 1'b1;
      if (c > 0) pend_st = 1'b1;
    end
    step();
    br_valid  = 1'b1;
    br_op     = 4'b1111;
    src_busy  = 1'b0;
    rs_data   = ~rs;
    rt_data   = ~rt;
    next_pc   = ~npc;
    br_offset = ~off;
    clear_exp();
    exp_redirect  = tk;
    exp_flush     = tk;
    exp_pc_target = tk ? tgt : m_hold;
    pend_br = 1'b1;
    pend_tk = tk;
    if (lit_tgt_en || lit_stall_en) begin
      @(negedge clk);
      if (lit_tgt_en)   checkOutput("lit_target", pc_target, lit_tgt);
      if (lit_stall_en) checkOutput("lit_perf_stall", perf_stall, lit_stall);
    end
    if (tk) m_hold = tgt;
    if (tk) begin
      step();
      br_valid = 1'b1;
      br_op    = T_BEQ;
      src_busy = 1'b0;
      rs_data  = 32'd0;
      rt_data  = 32'd0;
      clear_exp();
    end
    idle_cycle();
  endtask

  task automatic illegal_op(input logic [3:0] op, input logic busy);
    step();
    br_valid = 1'b1;
    br_op    = op;
    src_busy = busy;
    clear_exp();
    exp_err  = 1'b1;
    idle_cycle();
  endtask

  initial begin
    reset = 1'b1;
    br_valid = 1'b0; br_op = 4'd0; rs_data = '0; rt_data = '0;
    src_busy = 1'b0; br_offset = '0; next_pc = '0;
    m_hold = '0; exp_branches = '0; exp_taken = '0; exp_stallcnt = '0;
    pend_br = 1'b0; pend_tk = 1'b0; pend_st = 1'b0;
    clear_exp();
    repeat (2) @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    reset = 1'b0;
    step();
    clear_exp();
    check_en = 1'b1;
    idle_cycle();

    $display("[TB] beq taken, target 0x10C");
    applyStimulus(T_BEQ, 32'd5, 32'd5, 16'sd3, 32'h100, 0, 1'b1, 32'h10C, 1'b0, 32'd0);
    $display("[TB] bgt signed compare");
    applyStimulus(T_BGT, 32'hFFFF_FFFF, 32'd1, 16'd1, 32'h40, 0, 1'b0, 32'd0, 1'b0, 32'd0);
    applyStimulus(T_BGT, 32'd1, 32'hFFFF_FFFF, 16'd1, 32'h40, 0, 1'b1, 32'h44, 1'b0, 32'd0);
    $display("[TB] blt with 3 busy cycles");
    applyStimulus(T_BLT, 32'hFFFF_FFFB, 32'd2, 16'hFFFC, 32'h2000, 3, 1'b1, 32'h1FF0,
                  1'b1, PERF_ON ? 32'd3 : 32'd0);
    $display("[TB] offset sign-extension and wrap");
    applyStimulus(T_BNE, 32'd1, 32'd2, 16'h8000, 32'h10, 0, 1'b1, 32'hFFFE_0010, 1'b0, 32'd0);
    $display("[TB] remaining conditions");
    applyStimulus(T_BGE, 32'd3, 32'd3, 16'd8, 32'h300, 0, 1'b0, 32'd0, 1'b0, 32'd0);
    applyStimulus(T_BGE, 32'h8000_0000, 32'h7FFF_FFFF, 16'd8, 32'h300, 0, 1'b0, 32'd0, 1'b0, 32'd0);
    applyStimulus(T_BLE, 32'd4, 32'd3, 16'd2, 32'h400, 1, 1'b0, 32'd0, 1'b0, 32'd0);
    applyStimulus(T_BLE, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 16'd2, 32'h400, 2, 1'b0, 32'd0, 1'b0, 32'd0);
    applyStimulus(T_BEQ, 32'd5, 32'd6, 16'd4, 32'h500, 0, 1'b0, 32'd0, 1'b0, 32'd0);
    applyStimulus(T_BNE, 32'd9, 32'd9, 16'd4, 32'h500, 0, 1'b0, 32'd0, 1'b0, 32'd0);
    applyStimulus(T_BLT, 32'h7FFF_FFFF, 32'h8000_0000, 16'd4, 32'h600, 0, 1'b0, 32'd0, 1'b0, 32'd0);
    applyStimulus(T_BLT, 32'h8000_0000, 32'h7FFF_FFFF, 16'hFFFF, 32'h0, 0, 1'b1, 32'hFFFF_FFFC, 1'b0, 32'd0);

    $display("[TB] illegal opcodes");
    illegal_op(4'b1111, 1'b0);
    illegal_op(4'b0000, 1'b1);
    illegal_op(4'b1010, 1'b0);

    $display("[TB] reset during WAIT");
    step();
    br_valid = 1'b1; br_op = T_BLT; src_busy = 1'b1; rs_data = 32'd1; rt_data = 32'd2;
    br_offset = 16'd4; next_pc = 32'h700;
    clear_exp();
    exp_stall = 1'b1;
    step();
    clear_exp();
    exp_stall = 1'b1;
    pend_st = 1'b1;
    step();
    clear_exp();
    exp_stall = 1'b1;
    pend_st = 1'b1;
    @(negedge clk);
    #1;
    check_en = 1'b0;
    reset = 1'b1;
    pend_br = 1'b0; pend_tk = 1'b0; pend_st = 1'b0;
    m_hold = '0; exp_branches = '0; exp_taken = '0; exp_stallcnt = '0;
    clear_exp();
    #1;
    check_all();
    @(posedge clk);
    #1;
    check_all();
    @(negedge clk);
    br_valid = 1'b0;
    src_busy = 1'b0;
    reset = 1'b0;
    step();
    clear_exp();
    check_en = 1'b1;
    idle_cycle();
    applyStimulus(T_BEQ, 32'd7, 32'd7, 16'd1, 32'h800, 0, 1'b1, 32'h804, 1'b0, 32'd0);

    step();
    check_en = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
